// File: rtl/x2c_ctrl_pkg.sv
// Shared types and helpers for the X2C packet read sequencer.
// Holds state encoding, beat tag/payload structs and length-to-beat arithmetic.
package x2c_ctrl_pkg;

   localparam int unsigned WIDTH          = 256;
   localparam int unsigned PTR            = 10;
   localparam int unsigned LEN_W          = 16;
   localparam int unsigned MTY_W          = 5;
   localparam int unsigned BYTES_PER_BEAT = 32;
   localparam int unsigned BEATS_W        = LEN_W - MTY_W + 1;
   localparam int unsigned MAX_BEATS      = 1 << PTR;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      XFER = 2'd3
   } state_t;

   typedef struct packed {
      logic             sop;
      logic             eop;
      logic [MTY_W-1:0] mty;
   } tag_t;

   typedef struct packed {
      tag_t             tag;
      logic [WIDTH-1:0] data;
   } beat_t;

   // ceil(len / BYTES_PER_BEAT), wide enough for the largest length
   function automatic logic [BEATS_W-1:0] calc_beats(input logic [LEN_W-1:0] len);
      logic [LEN_W:0] sum;
      sum = {1'b0, len} + (LEN_W+1)'(BYTES_PER_BEAT - 1);
      return BEATS_W'(sum >> MTY_W);
   endfunction

   // unused bytes in the final beat; 0 when the length is a whole number of beats
   function automatic logic [MTY_W-1:0] calc_mty(input logic [LEN_W-1:0] len);
      logic [MTY_W:0] diff;
      diff = (MTY_W+1)'(BYTES_PER_BEAT) - {1'b0, len[MTY_W-1:0]};
      return diff[MTY_W-1:0];
   endfunction

endpackage

// File: rtl/x2c_skid_buf2.sv
// Two-entry register FIFO for {tag, data} beats with valid/ready output.
// The write side is unconditional; the upstream credit scheme prevents overflow.
module x2c_skid_buf2
   import x2c_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       aclr,
   input  logic       wr_en,
   input  beat_t      wr_beat,
   output logic [1:0] occ,
   output logic       out_valid,
   input  logic       out_ready,
   output beat_t      out_beat
);

   beat_t tail;
   logic  pop;

   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid & out_ready;

   // head register drives the output directly; tail only holds the second entry
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         occ      <= 2'd0;
         out_beat <= '0;
         tail     <= '0;
      end else begin
         case ({wr_en, pop})
            2'b10: begin
               if (occ == 2'd0) out_beat <= wr_beat;
               else             tail     <= wr_beat;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               out_beat <= tail;
               occ      <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  out_beat <= wr_beat;
               end else begin
                  out_beat <= tail;
                  tail     <= wr_beat;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/x2c_pkt_rd_ctrl.sv
// Packet read sequencer: pops a length descriptor, waits for the whole packet
// in the data FIFO, then streams ceil(len/32) beats with sop/eop/mty tags.
module x2c_pkt_rd_ctrl
   import x2c_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               aclr,
   input  logic               ctl_empty,
   output logic               ctl_rdreq,
   input  logic [LEN_W-1:0]   ctl_q,
   input  logic               dat_empty,
   input  logic [PTR:0]       dat_usedw,
   output logic               dat_rdreq,
   input  logic [WIDTH-1:0]   dat_q,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sop,
   output logic               out_eop,
   output logic [MTY_W-1:0]   out_mty,
   output logic               err_len,
   output logic               busy
);

   state_t             state, state_nxt;
   logic [PTR:0]       beats_rem, beats_rem_nxt;
   logic [MTY_W-1:0]   mty_r, mty_nxt;
   logic               first_r, first_nxt;
   logic               err_nxt;
   logic               rd_q;
   tag_t               tag_c, tag_q;
   logic [BEATS_W-1:0] load_beats;
   logic [1:0]         occ;
   logic               pop;
   logic [2:0]         pending;
   logic               credit;
   beat_t              wr_beat, head;

   assign load_beats = calc_beats(ctl_q);
   assign pop        = out_valid & out_ready;
   // beats that will occupy the skid buffer after this cycle without a new read
   assign pending    = 3'(occ) + 3'(rd_q) - 3'(pop);
   assign credit     = (pending < 3'd2);

   always_comb begin
      state_nxt     = state;
      beats_rem_nxt = beats_rem;
      mty_nxt       = mty_r;
      first_nxt     = first_r;
      err_nxt       = 1'b0;
      ctl_rdreq     = 1'b0;
      dat_rdreq     = 1'b0;
      case (state)
         IDLE: begin
            ctl_rdreq = !ctl_empty && !aclr;
            if (ctl_rdreq) state_nxt = LOAD;
         end
         LOAD: begin
            if ((ctl_q == '0) || (load_beats > BEATS_W'(MAX_BEATS))) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               beats_rem_nxt = (PTR+1)'(load_beats);
               mty_nxt       = calc_mty(ctl_q);
               first_nxt     = 1'b1;
               state_nxt     = WAIT;
            end
         end
         WAIT: begin
            if (dat_usedw >= beats_rem) state_nxt = XFER;
         end
         XFER: begin
            dat_rdreq = !dat_empty && credit;
            if (dat_rdreq) begin
               beats_rem_nxt = beats_rem - (PTR+1)'(1);
               first_nxt     = 1'b0;
               if (beats_rem == (PTR+1)'(1)) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tag_c.sop = first_r;
      tag_c.eop = (beats_rem == (PTR+1)'(1));
      tag_c.mty = tag_c.eop ? mty_r : MTY_W'(0);
   end

   // tags and read strobe delayed one cycle to line up with dat_q
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state     <= IDLE;
         beats_rem <= '0;
         mty_r     <= '0;
         first_r   <= 1'b0;
         err_len   <= 1'b0;
         rd_q      <= 1'b0;
         tag_q     <= '0;
      end else begin
         state     <= state_nxt;
         beats_rem <= beats_rem_nxt;
         mty_r     <= mty_nxt;
         first_r   <= first_nxt;
         err_len   <= err_nxt;
         rd_q      <= dat_rdreq;
         tag_q     <= tag_c;
      end
   end

   assign wr_beat.tag  = tag_q;
   assign wr_beat.data = dat_q;

   x2c_skid_buf2 u_skid (
      .clk       (clk),
      .aclr      (aclr),
      .wr_en     (rd_q),
      .wr_beat   (wr_beat),
      .occ       (occ),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_beat  (head)
   );

   assign out_data = head.data;
   assign out_sop  = head.tag.sop;
   assign out_eop  = head.tag.eop;
   assign out_mty  = head.tag.mty;
   assign busy     = (state != IDLE) || (occ != 2'd0) || rd_q;

endmodule

// File: tb/tb_x2c_pkt_rd_ctrl.sv
// Bench for x2c_pkt_rd_ctrl: FIFO models, packet-level scoreboard and
// directed scenarios with hand-computed timing expectations.
module tb_x2c_pkt_rd_ctrl;

   typedef struct {
      logic [255:0] data;
      bit           sop;
      bit           eop;
      int           mty;
   } exp_t;

   typedef struct {
      int cyc;
      bit sop;
      bit eop;
      int mty;
   } rec_t;

   logic          clk = 1'b0;
   logic          aclr;
   logic          ctl_empty = 1'b1;
   logic          ctl_rdreq;
   logic [15:0]   ctl_q = '0;
   logic          dat_empty = 1'b1;
   logic [10:0]   dat_usedw = '0;
   logic          dat_rdreq;
   logic [255:0]  dat_q = '0;
   logic [255:0]  out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_sop, out_eop;
   logic [4:0]    out_mty;
   logic          err_len;
   logic          busy;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            issued = 0;
   int            popped = 0;
   int            usedw_cap = 1024;
   bit            rdy_pat_en = 1'b0;
   bit            rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   int            pidx = 0;
   int            seq = 1;
   int            c0;
   int            n;

   logic [15:0]   ctl_fifo [$];
   logic [255:0]  dat_fifo [$];
   exp_t          exp_q [$];
   exp_t          e;
   int            ctl_log [$];
   int            rd_log [$];
   int            err_log [$];
   rec_t          beat_log [$];
   rec_t          r;

   always #5 clk = ~clk;

   x2c_pkt_rd_ctrl dut (
      .clk       (clk),
      .aclr      (aclr),
      .ctl_empty (ctl_empty),
      .ctl_rdreq (ctl_rdreq),
      .ctl_q     (ctl_q),
      .dat_empty (dat_empty),
      .dat_usedw (dat_usedw),
      .dat_rdreq (dat_rdreq),
      .dat_q     (dat_q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_mty   (out_mty),
      .err_len   (err_len),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   // queue one descriptor plus its data words and the beats the consumer must see
   task automatic send_pkt(input int len);
      int nb;
      exp_t x;
      ctl_fifo.push_back(16'(len));
      nb = (len + 31) / 32;
      if (len > 0 && nb <= 1024) begin
         for (int i = 0; i < nb; i++) begin
            x.data = {8{32'(seq)}};
            x.sop  = (i == 0);
            x.eop  = (i == nb - 1);
            x.mty  = (i == nb - 1) ? (32 - len % 32) % 32 : 0;
            seq++;
            dat_fifo.push_back(x.data);
            exp_q.push_back(x);
         end
      end
   endtask

   task automatic clear_logs();
      ctl_log.delete();
      rd_log.delete();
      err_log.delete();
      beat_log.delete();
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (!(exp_q.size() == 0 && ctl_fifo.size() == 0 && !busy) && k < 600) begin
         @(posedge clk); #1;
         k++;
      end
      chk({name, "_drain_timeout"}, 64'(k >= 600), 64'd0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ctl_rdreq"}, 64'(ctl_rdreq), 64'd0);
      chk({name, "_dat_rdreq"}, 64'(dat_rdreq), 64'd0);
      chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_out_sop"},   64'(out_sop),   64'd0);
      chk({name, "_out_eop"},   64'(out_eop),   64'd0);
      chk({name, "_out_mty"},   64'(out_mty),   64'd0);
      chk({name, "_out_data"},  64'(|out_data), 64'd0);
      chk({name, "_err_len"},   64'(err_len),   64'd0);
      chk({name, "_busy"},      64'(busy),      64'd0);
   endtask

   initial begin
      fork
         // compare process: scoreboard every accepted beat, bound buffered+in-flight beats
         forever begin
            @(negedge clk);
            cyc++;
            if (aclr) begin
               exp_q.delete();
               issued = 0;
               popped = 0;
            end else begin
               checks++;
               if (issued - popped > 2) begin
                  errors++;
                  $display("FAIL outstanding act=%0d exp<=2", issued - popped);
               end
               if (ctl_rdreq) ctl_log.push_back(cyc);
               if (err_len)   err_log.push_back(cyc);
               if (dat_rdreq) begin
                  rd_log.push_back(cyc);
                  issued++;
               end
               if (out_valid && out_ready) begin
                  popped++;
                  r.cyc = cyc; r.sop = out_sop; r.eop = out_eop; r.mty = int'(out_mty);
                  beat_log.push_back(r);
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL beat_unexpected act_data=%h exp=none", out_data);
                  end else begin
                     e = exp_q.pop_front();
                     if (out_data !== e.data || out_sop !== e.sop || out_eop !== e.eop ||
                         {27'd0, out_mty} !== 32'(e.mty)) begin
                        errors++;
                        $display("FAIL beat act data=%h sop=%0b eop=%0b mty=%0d exp data=%h sop=%0b eop=%0b mty=%0d",
                                 out_data, out_sop, out_eop, out_mty, e.data, e.sop, e.eop, e.mty);
                     end
                  end
               end
            end
         end
         // control/data FIFO models: show-ahead-free, data valid the cycle after rdreq
         forever begin
            @(posedge clk or posedge aclr);
            if (aclr) begin
               ctl_fifo.delete();
               dat_fifo.delete();
               ctl_q     <= '0;
               dat_q     <= '0;
               ctl_empty <= 1'b1;
               dat_empty <= 1'b1;
               dat_usedw <= '0;
            end else begin
               if (ctl_rdreq && ctl_fifo.size() > 0) ctl_q <= ctl_fifo.pop_front();
               if (dat_rdreq && dat_fifo.size() > 0) dat_q <= dat_fifo.pop_front();
               ctl_empty <= (ctl_fifo.size() == 0);
               dat_empty <= (dat_fifo.size() == 0);
               n = dat_fifo.size();
               if (n > usedw_cap) n = usedw_cap;
               dat_usedw <= 11'(n);
            end
         end
         // consumer ready driver
         forever begin
            @(posedge clk); #1;
            if (rdy_pat_en) begin
               out_ready = rdy_pat[pidx];
               pidx = (pidx + 1) % 6;
            end else begin
               out_ready = 1'b1;
            end
         end
      join_none

      // reset state
      aclr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      aclr = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // 64 bytes: exact cycle positions relative to the descriptor pop
      clear_logs();
      send_pkt(64);
      wait_drain("len64");
      c0 = ctl_log[0];
      chk("len64_nrd", 64'(rd_log.size()), 64'd2);
      chk("len64_rd0", 64'(rd_log[0] - c0), 64'd3);
      chk("len64_rd1", 64'(rd_log[1] - c0), 64'd4);
      chk("len64_nbeat", 64'(beat_log.size()), 64'd2);
      chk("len64_v0", 64'(beat_log[0].cyc - c0), 64'd5);
      chk("len64_sop", 64'(beat_log[0].sop), 64'd1);
      chk("len64_v1", 64'(beat_log[1].cyc - c0), 64'd6);
      chk("len64_eop", 64'(beat_log[1].eop), 64'd1);
      chk("len64_mty", 64'(beat_log[1].mty), 64'd0);

      // 33 bytes: two beats, 31 empty bytes at the end
      clear_logs();
      send_pkt(33);
      wait_drain("len33");
      chk("len33_nbeat", 64'(beat_log.size()), 64'd2);
      chk("len33_mty", 64'(beat_log[1].mty), 64'd31);

      // 32 bytes: single beat carrying both sop and eop
      clear_logs();
      send_pkt(32);
      wait_drain("len32");
      chk("len32_nbeat", 64'(beat_log.size()), 64'd1);
      chk("len32_sopeop", 64'({beat_log[0].sop, beat_log[0].eop}), 64'd3);
      chk("len32_mty", 64'(beat_log[0].mty), 64'd0);

      // zero length dropped with a single-cycle error, next packet unaffected
      clear_logs();
      send_pkt(0);
      send_pkt(64);
      wait_drain("len0");
      chk("len0_err_cnt", 64'(err_log.size()), 64'd1);
      chk("len0_nrd", 64'(rd_log.size()), 64'd2);
      chk("len0_rd_after_err", 64'(rd_log[0] > err_log[0]), 64'd1);
      chk("len0_nbeat", 64'(beat_log.size()), 64'd2);

      // store-and-forward: no reads until the whole 10-beat packet is present
      clear_logs();
      usedw_cap = 4;
      send_pkt(320);
      repeat (20) @(posedge clk);
      #1;
      chk("sf_desc_popped", 64'(ctl_log.size()), 64'd1);
      chk("sf_no_rd", 64'(rd_log.size()), 64'd0);
      usedw_cap = 1024;
      wait_drain("sf");
      chk("sf_nrd", 64'(rd_log.size()), 64'd10);
      chk("sf_consecutive", 64'(rd_log[9] - rd_log[0]), 64'd9);
      chk("sf_nbeat", 64'(beat_log.size()), 64'd10);

      // backpressure: 16 beats through a stalling consumer
      clear_logs();
      rdy_pat_en = 1'b1;
      send_pkt(512);
      wait_drain("bp");
      rdy_pat_en = 1'b0;
      chk("bp_nrd", 64'(rd_log.size()), 64'd16);
      chk("bp_nbeat", 64'(beat_log.size()), 64'd16);
      chk("bp_last_eop", 64'(beat_log[15].eop), 64'd1);

      // reset mid-transfer, then a fresh packet
      clear_logs();
      send_pkt(320);
      n = 0;
      while (rd_log.size() < 4 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_mid_start_timeout", 64'(n >= 100), 64'd0);
      @(posedge clk);
      #2;
      aclr = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      @(posedge clk);
      #1;
      aclr = 1'b0;
      #1;
      chk("rst_mid_idle", 64'(busy), 64'd0);
      @(posedge clk); #1;
      clear_logs();
      send_pkt(96);
      wait_drain("post_rst");
      chk("post_rst_nbeat", 64'(beat_log.size()), 64'd3);
      chk("post_rst_sop", 64'(beat_log[0].sop), 64'd1);
      chk("post_rst_eop", 64'(beat_log[2].eop), 64'd1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/x2c_pkt_rd_ctrl.md
# x2c_pkt_rd_ctrl

Packet read sequencer for the X2C data path. It pops one packet-length descriptor from the X2C control FIFO, waits until the 1024x256 data FIFO holds the whole packet, then issues exactly ceil(len/32) reads to that FIFO. It presents the beats as a valid/ready stream with sop, eop and an empty-byte count on the last beat. It sits between the data/control FIFO pair and the downstream core-side consumer.

## Interface
- WIDTH, 256, data beat width in bits (32 bytes)
- PTR, 10, data FIFO address bits; the usedw input is PTR+1 bits
- LEN_W, 16, descriptor length field width, in bytes
- MTY_W, 5, log2(WIDTH/8)

Ports:
- clk  in  1  single clock for the block and both FIFOs
- aclr  in  1  asynchronous, active-high reset
- ctl_empty  in  1  control FIFO empty
- ctl_rdreq  out  1  control FIFO pop; standard read, so ctl_q is valid on the next cycle
- ctl_q  in  LEN_W  packet length in bytes
- dat_empty  in  1  data FIFO empty
- dat_usedw  in  PTR+1  data FIFO occupancy
- dat_rdreq  out  1  data FIFO pop; dat_q is valid on the next cycle
- dat_q  in  WIDTH  data FIFO output
- out_data  out  WIDTH  beat data
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accept
- out_sop / out_eop  out  1  first / last beat of packet
- out_mty  out  MTY_W  empty bytes in the last beat; 0 on all other beats
- err_len  out  1  one-cycle pulse when a descriptor is dropped
- busy  out  1  high whenever state != IDLE or any beat is buffered or in flight

## Operation
- FSM states are IDLE, LOAD, WAIT and XFER.
- IDLE: ctl_rdreq = !ctl_empty (combinational). If ctl_rdreq is high, go to LOAD.
- LOAD: register len = ctl_q.
  - beats = (len+31)>>5; mty = (32 - len[4:0]) & 31.
  - If len == 0 or beats > 2**PTR: pulse err_len, drop the descriptor, return to IDLE.
  - Otherwise load beats_rem = beats and go to WAIT.
- WAIT: when dat_usedw >= beats_rem, go to XFER. This is store-and-forward: a packet never starts partially.
- XFER: dat_rdreq = !dat_empty & credit.
  - Each read decrements beats_rem.
  - The first read of the packet is tagged sop. The read with beats_rem == 1 is tagged eop and carries mty.
  - After the eop read, go to IDLE. The next descriptor may be fetched while earlier beats drain.
- Tag pipeline: {sop, eop, mty, rd} is registered once, aligned with dat_q, and written into a 2-entry skid buffer together with dat_q.
- Credit: credit = (occ + inflight - pop) < 2.
  - occ is the skid-buffer occupancy, 0..2.
  - inflight is the registered dat_rdreq.
  - pop = out_valid & out_ready.
  - This sustains 1 beat/cycle with out_ready held high, and the buffer can never overflow.
- The stream contract:
  - out_valid is held with data and tags stable until accepted.
  - Beats leave in FIFO order, with no loss or duplication.
- dat_empty asserted in XFER (which should not happen, given the usedw check) only stalls reads; there is no error.

## Timing
- On aclr: state = IDLE, occ = 0, inflight = 0. Every output is 0: ctl_rdreq, dat_rdreq, out_valid, out_sop, out_eop, out_mty, out_data, err_len, busy.
- aclr mid-packet discards every buffered and in-flight beat. The top level drives the same aclr into both FIFOs so descriptors and data stay aligned.
- Cycle 0 is the first cycle with ctl_empty low in IDLE, with sufficient usedw and out_ready high:
  - ctl_rdreq at cycle 0
  - LOAD at cycle 1
  - WAIT at cycle 2
  - first dat_rdreq at cycle 3
  - dat_q at cycle 4
  - out_valid & out_sop at cycle 5
- Descriptor-to-first-beat latency is therefore 5 cycles. Read-to-out_valid latency is 2 cycles.
- Minimum gap between back-to-back packets is 3 idle read cycles (IDLE, LOAD, WAIT).
- A beat with sop and eop together is legal (len ≤ 32).

## Structure
- Package x2c_ctrl_pkg holds:
  - state encoding (2-bit enum: IDLE, LOAD, WAIT, XFER)
  - BYTES_PER_BEAT = 32
  - the beats/mty helper functions
  - the tag struct {sop, eop, mty}
- Sub-module x2c_skid_buf2: 2-entry register FIFO for {tag, data}, with the occ output, valid/ready on the output side, and an unconditional write on the input side.
- The top module holds the FSM, counters and credit logic.

## Test plan
- len=64, usedw=2, ready=1: ctl_rdreq at cycle 0, dat_rdreq at cycles 3–4, out_valid at cycles 5–6, sop at 5, eop at 6, mty=0.
- len=33: 2 beats, out_mty=31 on the eop beat. len=32: 1 beat with sop=eop=1 and mty=0.
- len=0, then len=64: err_len pulses exactly 1 cycle, no dat_rdreq for the first descriptor, and the 64-byte packet is then delivered normally.
- len=320 (10 beats), usedw held at 4 for 20 cycles then raised to 10: zero dat_rdreq while usedw < 10, then 10 consecutive reads.
- out_ready pattern 1,0,0,1,0,1… over a 16-beat packet with incrementing data: occ+inflight never exceeds 2, and the output sequence exactly matches the input sequence.
- aclr asserted for 1 cycle mid-XFER of a 10-beat packet: all outputs drop to 0 asynchronously, state returns to IDLE, and after release a fresh descriptor completes correctly.
